button_debouncer: RTL and testbench



---
 rtl/button_pkg.sv | 24 ++
 rtl/button_channel.sv | 119 +++++++++++
 rtl/button_debouncer.sv | 40 ++++
 tb/tb_button_debouncer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and types for the push-button front end: 50 MHz default
// timings, board button indices and the counter-width helper.
package button_pkg;

  localparam int unsigned DEF_N_BUTTONS       = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;     // 1 ms at 50 MHz
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 0.5 s at 50 MHz
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 0.1 s at 50 MHz

  localparam int unsigned BTN_WRITE = 0;  // S1
  localparam int unsigned BTN_NEXT  = 1;  // S2
  localparam int unsigned BTN_VALUE = 2;  // S3
  localparam int unsigned BTN_LATCH = 3;  // S4

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_PRESSED  = 1'b1
  } btn_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One debounced button: 2-flop synchroniser, stability counter, level state
// and press/release pulses. Auto-repeat is built only with BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RAW_IDLE = ACTIVE_LOW;

  logic             sync1_q, sync2_q;
  logic             sample;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept;
  logic             rep_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q ^ RAW_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BTN_RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Accept on the cycle the counter would reach DEBOUNCE_CYCLES, so the
  // counter itself never holds that value.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    accept  = 1'b0;
    if (sample != (state_q == BTN_PRESSED)) begin
      if (cnt_q == CNT_LAST) begin
        accept  = 1'b1;
        state_d = (state_q == BTN_PRESSED) ? BTN_RELEASED : BTN_PRESSED;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press_d   = (accept && (state_q == BTN_RELEASED)) || rep_pulse;
  assign release_d = accept && (state_q == BTN_PRESSED);

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = cnt_width(REP_MAX);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  // While pressed the counter runs; an accept here is a release and wins.
  always_comb begin
    rep_cnt_d   = '0;
    rep_first_d = 1'b1;
    rep_pulse   = 1'b0;
    if ((state_q == BTN_PRESSED) && !accept) begin
      rep_first_d = rep_first_q;
      if (rep_cnt_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
        rep_pulse   = 1'b1;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign state_o   = (state_q == BTN_PRESSED);
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Board push-button front end: N independent debounced channels plus a
// combined press flag. Optional auto-repeat: BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = DEF_N_BUTTONS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_state,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] release_evt,
  output logic                 any_press
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (btn_raw[i]),
      .state_o   (btn_state[i]),
      .press_o   (press[i]),
      .release_o (release_evt[i])
    );
  end

  // press is already registered per channel, so the OR lines up with it.
  assign any_press = |press;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (DEBOUNCE_CYCLES=8, active-low pins).
module tb_button_debouncer;
  import button_pkg::*;

  localparam int NB  = 4;
  localparam int DC  = 8;
  localparam int RD  = 20;
  localparam int RP  = 6;
  localparam int LAT = DC + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_state;
  logic [NB-1:0] press;
  logic [NB-1:0] release_evt;
  logic          any_press;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_debouncer #(
    .N_BUTTONS       (NB),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1'b1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_state   (btn_state),
    .press       (press),
    .release_evt (release_evt),
    .any_press   (any_press)
  );

  // event code: cycle*16 + channel*2 + kind (1 = press, 0 = release); channel NB = any_press
  function automatic int ev(input int c, input int ch, input int kind);
    return c * 16 + ch * 2 + kind;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (press[i] === 1'b1)       obs_q.push_back(ev(cyc, i, 1));
      if (release_evt[i] === 1'b1) obs_q.push_back(ev(cyc, i, 0));
    end
    if (any_press === 1'b1) obs_q.push_back(ev(cyc, NB, 1));
  end

  task automatic expect_press(input int c, input int ch);
    exp_q.push_back(ev(c, ch, 1));
    exp_q.push_back(ev(c, NB, 1));
  endtask

  task automatic test_reset();
    int e, o;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_tests++;
      if ({btn_state, press, release_evt, any_press} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b required 0", {btn_state, press, release_evt, any_press});
      end
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_evt_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_evt: got code %0d required code %0d", o, e);
      end
    end
  endtask

  task automatic test_single_press();
    int k, e, o;
    @(posedge clk); #1;
    btn_raw[BTN_WRITE] = 1'b0;
    k = cyc;
    expect_press(k + LAT, BTN_WRITE);
    repeat (15) @(posedge clk); #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_evt_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_evt: got cyc%0d ch%0d k%0d required cyc%0d ch%0d k%0d",
                 o / 16, (o % 16) / 2, o % 2, e / 16, (e % 16) / 2, e % 2);
      end
    end
    n_tests++;
    if (btn_state !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_state: got %b required 0001", btn_state);
    end
  endtask

  task automatic test_bounce();
    int k, e, o;
    for (int i = 0; i < 4; i++) begin
      btn_raw[BTN_NEXT] = (i % 2 == 1);
      repeat (3) @(posedge clk); #1;
    end
    btn_raw[BTN_NEXT] = 1'b0;
    k = cyc;
    expect_press(k + LAT, BTN_NEXT);
    repeat (15) @(posedge clk); #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bounce_evt_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bounce_evt: got cyc%0d ch%0d k%0d required cyc%0d ch%0d k%0d",
                 o / 16, (o % 16) / 2, o % 2, e / 16, (e % 16) / 2, e % 2);
      end
    end
    n_tests++;
    if (btn_state !== 4'b0011) begin
      n_fail++;
      $display("FAIL bounce_state: got %b required 0011", btn_state);
    end
  endtask

  task automatic test_release();
    int k, e, o;
    @(posedge clk); #1;
    btn_raw[BTN_WRITE] = 1'b1;
    k = cyc;
    exp_q.push_back(ev(k + LAT, BTN_WRITE, 0));
    repeat (15) @(posedge clk); #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL release_evt_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL release_evt: got cyc%0d ch%0d k%0d required cyc%0d ch%0d k%0d",
                 o / 16, (o % 16) / 2, o % 2, e / 16, (e % 16) / 2, e % 2);
      end
    end
    n_tests++;
    if (btn_state !== 4'b0010) begin
      n_fail++;
      $display("FAIL release_state: got %b required 0010", btn_state);
    end
  endtask

  task automatic test_reset_midcount();
    int k, e, o;
    @(posedge clk); #1;
    btn_raw[BTN_LATCH] = 1'b0;
    repeat (7) @(posedge clk);  // channel 3 counter now holds 5
    #2;
    n_tests++;
    if (btn_state !== 4'b0010) begin
      n_fail++;
      $display("FAIL midcount_pre_state: got %b required 0010", btn_state);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({btn_state, press, release_evt, any_press} !== '0) begin
      n_fail++;
      $display("FAIL midcount_async_clear: got %b required 0", {btn_state, press, release_evt, any_press});
    end
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    k = cyc;
    exp_q.push_back(ev(k + LAT, BTN_NEXT, 1));
    exp_q.push_back(ev(k + LAT, BTN_LATCH, 1));
    exp_q.push_back(ev(k + LAT, NB, 1));
    repeat (15) @(posedge clk); #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midcount_evt_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midcount_evt: got cyc%0d ch%0d k%0d required cyc%0d ch%0d k%0d",
                 o / 16, (o % 16) / 2, o % 2, e / 16, (e % 16) / 2, e % 2);
      end
    end
    n_tests++;
    if (btn_state !== 4'b1010) begin
      n_fail++;
      $display("FAIL midcount_state: got %b required 1010", btn_state);
    end
  endtask

  task automatic test_simultaneous_release();
    int k, e, o;
    @(posedge clk); #1;
    btn_raw[BTN_NEXT]  = 1'b1;
    btn_raw[BTN_LATCH] = 1'b1;
    k = cyc;
    exp_q.push_back(ev(k + LAT, BTN_NEXT, 0));
    exp_q.push_back(ev(k + LAT, BTN_LATCH, 0));
    repeat (15) @(posedge clk); #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL simul_evt_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL simul_evt: got cyc%0d ch%0d k%0d required cyc%0d ch%0d k%0d",
                 o / 16, (o % 16) / 2, o % 2, e / 16, (e % 16) / 2, e % 2);
      end
    end
    n_tests++;
    if (btn_state !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_state: got %b required 0000", btn_state);
    end
  endtask

  task automatic test_autorepeat();
    int k, a, e, o;
    @(posedge clk); #1;
    btn_raw[BTN_VALUE] = 1'b0;
    k = cyc;
    a = k + LAT;
    expect_press(a, BTN_VALUE);
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    for (int t = a + RD; t < a + 60; t += RP) expect_press(t, BTN_VALUE);
`endif
    repeat (60) @(posedge clk); #1;
    btn_raw[BTN_VALUE] = 1'b1;
    exp_q.push_back(ev(cyc + LAT, BTN_VALUE, 0));
    repeat (20) @(posedge clk); #1;
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL repeat_evt_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      o = (obs_q.size() != 0) ? obs_q.pop_front() : -1;
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL repeat_evt: got cyc%0d ch%0d k%0d required cyc%0d ch%0d k%0d",
                 o / 16, (o % 16) / 2, o % 2, e / 16, (e % 16) / 2, e % 2);
      end
    end
    n_tests++;
    if (btn_state !== 4'b0000) begin
      n_fail++;
      $display("FAIL repeat_state: got %b required 0000", btn_state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    btn_raw = '1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_release();
    test_reset_midcount();
    test_simultaneous_release();
    test_autorepeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
